zx_mapper: RTL and testbench



---
 rtl/zx_mapper.sv | 109 ++++++++++
 tb/tb_zx_mapper.sv | 119 +++++++++++
 2 files changed

// File: rtl/zx_mapper.sv
// zx_mapper: 128K/+3 memory mapper decoding 7FFD paging into 8K physical pages, with divMMC overlay.
// Optional +3 paging (1FFD, special all-RAM modes, 4 ROMs) is enabled by defining PLUS3_PAGING_EN.
module zx_mapper #(
   parameter int ADDR_W     = 21,
   parameter int BANKS      = 8,
   parameter int ROMS       = 2,
   parameter int ROM_PG     = 128,
   parameter int DIV_ROM_PG = 192,
   parameter int DIV_RAM_PG = 208
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ce,
   input  logic              mreq,
   input  logic              iorq,
   input  logic              wr,
   input  logic [7:0]        d,
   input  logic [15:0]       a,
   input  logic              divMap,
   input  logic              divRam,
   input  logic [3:0]        divPage,
   output logic [ADDR_W-1:0] memA,
   output logic              memWe,
   output logic              vidBank,
   output logic              contend,
   output logic              locked
);
   localparam int PW = ADDR_W - 13;
   localparam int BB = $clog2(BANKS);
   typedef enum logic {ARMED, DONE} detState_t;
   detState_t detState;
   logic [BB-1:0] pageBank, ramBank;
   logic [PW-1:0] page;
   logic [1:0] slot;
   logic romLo, hit7ffd, anyHit, isRam, divArea, isDivRam, ramHit, wrProt;
   assign slot = a[15:14];
   assign hit7ffd = !iorq && !wr && !a[15] && !a[1];
`ifdef PLUS3_PAGING_EN
   logic [2:0] p3;
   logic [2:0] spBank;
   logic [1:0] rom;
   logic hit1ffd;
   assign rom = {p3[2], romLo};
   assign hit1ffd = !iorq && !wr && a[15:12] == 4'b0001 && !a[1];
   assign anyHit = hit7ffd || hit1ffd;
   if (ROMS != 2 && ROMS != 4) begin : gBadRoms
      $error("zx_mapper: ROMS must be 2 or 4");
   end
`else
   logic rom;
   assign rom = romLo;
   assign anyHit = hit7ffd;
   if (ROMS != 2) begin : gBadRoms
      $error("zx_mapper: ROMS > 2 requires PLUS3_PAGING_EN");
   end
`endif
   always_comb begin
      ramBank = slot == 2'd1 ? BB'(5) : slot == 2'd2 ? BB'(2) : pageBank;
      isRam = slot != 2'd0;
`ifdef PLUS3_PAGING_EN
      // special modes: 00:0123 01:4567 10:4563 11:4763
      spBank = p3[2:1] == 2'd0 ? {1'b0, slot} : p3[2:1] == 2'd1 ? {1'b1, slot} :
               slot == 2'd3 ? 3'd3 : (p3[2:1] == 2'd3 && slot == 2'd1) ? 3'd7 : {1'b1, slot};
      ramBank = p3[0] ? BB'(spBank) : ramBank;
      isRam = p3[0] || isRam;
`endif
      divArea = divMap && slot == 2'd0;
      isDivRam = divArea && a[13] && divRam;
      ramHit = isRam && !divArea;
      page = divArea ? (isDivRam ? PW'(DIV_RAM_PG) + PW'(divPage) : PW'(DIV_ROM_PG)) :
             isRam ? PW'({ramBank, a[13]}) : PW'(ROM_PG) + PW'({rom, a[13]});
      // divMMC RAM page 3 is only writable outside the overlay, so it is read-only here
      wrProt = divArea ? !(isDivRam && divPage != 4'd3) : !ramHit;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         detState <= ARMED;
         pageBank <= '0;
         romLo    <= 1'b0;
         vidBank  <= 1'b0;
         locked   <= 1'b0;
         memA     <= '0;
         memWe    <= 1'b1;
         contend  <= 1'b0;
`ifdef PLUS3_PAGING_EN
         p3       <= '0;
`endif
      end else if (ce) begin
         memA    <= {page, a[12:0]};
         memWe   <= wrProt || mreq || wr;
         contend <= !mreq && ramHit && ramBank[0];
         if (iorq)
            detState <= ARMED;
         else if (detState == ARMED && anyHit) begin
            detState <= DONE;
            if (!locked && hit7ffd) begin
               pageBank <= BB'({d[7:6], d[2:0]});
               vidBank  <= d[3];
               romLo    <= d[4];
               locked   <= d[5];
            end
`ifdef PLUS3_PAGING_EN
            if (!locked && hit1ffd)
               p3 <= d[2:0];
`endif
         end
      end
   end
endmodule

// File: tb/tb_zx_mapper.sv
// tb_zx_mapper: directed checks of zx_mapper paging, lock, write detector, protection and divMMC overlay.
module tb_zx_mapper;
   logic clock = 1'b0, reset = 1'b1, ce = 1'b1, mreq = 1'b1, iorq = 1'b1, wr = 1'b1;
   logic [7:0] d = '0;
   logic [15:0] a = '0;
   logic divMap = 1'b0, divRam = 1'b0;
   logic [3:0] divPage = '0;
   logic [20:0] memA;
   logic memWe, vidBank, contend, locked;
   int checks = 0, errors = 0;

   zx_mapper dut (.clock(clock), .reset(reset), .ce(ce), .mreq(mreq), .iorq(iorq), .wr(wr), .d(d), .a(a),
                  .divMap(divMap), .divRam(divRam), .divPage(divPage), .memA(memA), .memWe(memWe),
                  .vidBank(vidBank), .contend(contend), .locked(locked));

   always #5 clock = ~clock;

   function automatic logic [20:0] pa(input int pg, input logic [15:0] ad);
      return {8'(pg), ad[12:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic outPort(input logic [15:0] port, input logic [7:0] val);
      mreq = 1'b1; a = port; d = val; iorq = 1'b0; wr = 1'b0;
      step();
      iorq = 1'b1; wr = 1'b1;
      step();
   endtask

   task automatic rd(input logic [15:0] ad);
      iorq = 1'b1; wr = 1'b1; mreq = 1'b0; a = ad;
      step();
   endtask

   task automatic wrMem(input logic [15:0] ad);
      iorq = 1'b1; wr = 1'b0; mreq = 1'b0; a = ad;
      step();
      wr = 1'b1;
   endtask

   initial begin
      step(); step();
      chk("rst memA", memA, 0);
      chk("rst memWe", memWe, 1);
      chk("rst vidBank", vidBank, 0);
      chk("rst contend", contend, 0);
      chk("rst locked", locked, 0);
      reset = 1'b0;
      rd(16'h0000); chk("rd 0000", memA, pa(128, 16'h0000)); chk("contend rom", contend, 0);
      rd(16'h4123); chk("rd 4123", memA, pa(10, 16'h4123)); chk("contend bank5", contend, 1);
      rd(16'h8000); chk("rd 8000", memA, pa(4, 16'h8000)); chk("contend bank2", contend, 0);
      rd(16'hC000); chk("rd C000", memA, pa(0, 16'hC000));
      wrMem(16'h0000); chk("rom we", memWe, 1);
      wrMem(16'h8000); chk("ram we", memWe, 0);
      outPort(16'h7FFD, 8'h13);
      rd(16'hC000); chk("bank3 C000", memA, pa(6, 16'hC000)); chk("contend bank3", contend, 1);
      rd(16'h0000); chk("rom1 0000", memA, pa(130, 16'h0000));
      rd(16'h2000); chk("rom1 2000", memA, pa(131, 16'h2000));
      chk("vid 0x13", vidBank, 0);
      outPort(16'h7FFD, 8'h28);
      outPort(16'h7FFD, 8'h07);
      chk("locked", locked, 1);
      chk("vid locked", vidBank, 1);
      rd(16'hC000); chk("locked C000", memA, pa(0, 16'hC000));
      rd(16'h0000); chk("locked 0000", memA, pa(128, 16'h0000));
      reset = 1'b1; step(); reset = 1'b0;
      chk("unlock rst", locked, 0);
      outPort(16'h7FFD, 8'h07);
      chk("unlocked", locked, 0);
      rd(16'hC000); chk("bank7 C000", memA, pa(14, 16'hC000)); chk("contend bank7", contend, 1);
      rd(16'hE000); chk("bank7 E000", memA, pa(15, 16'hE000));
      mreq = 1'b1; a = 16'h7FFD; d = 8'h01; iorq = 1'b0; wr = 1'b0;
      step();
      d = 8'h02;
      repeat (4) step();
      iorq = 1'b1; wr = 1'b1;
      step();
      rd(16'hC000); chk("long wr", memA, pa(2, 16'hC000));
      outPort(16'h7FFD, 8'h02);
      rd(16'hC000); chk("rearm", memA, pa(4, 16'hC000));
      ce = 1'b0;
      rd(16'h8000); chk("ce hold", memA, pa(4, 16'hC000));
      outPort(16'h7FFD, 8'h05);
      ce = 1'b1;
      rd(16'hC000); chk("ce no latch", memA, pa(4, 16'hC000));
      divMap = 1'b1; divRam = 1'b1; divPage = 4'd5;
      rd(16'h2000); chk("div ram", memA, pa(213, 16'h2000)); chk("div contend", contend, 0);
      wrMem(16'h2000); chk("div ram we", memWe, 0);
      divPage = 4'd3;
      wrMem(16'h2000); chk("div pg3 we", memWe, 1);
      rd(16'h0000); chk("div rom 0000", memA, pa(192, 16'h0000));
      divRam = 1'b0;
      rd(16'h2000); chk("div rom 2000", memA, pa(192, 16'h2000));
      wrMem(16'h2000); chk("div rom we", memWe, 1);
      divMap = 1'b0;
`ifdef PLUS3_PAGING_EN
      outPort(16'h1FFD, 8'h01);
      rd(16'h0000); chk("special 0000", memA, pa(0, 16'h0000));
      wrMem(16'h0000); chk("special we", memWe, 0);
      divMap = 1'b1;
      rd(16'h0000); chk("special div", memA, pa(192, 16'h0000));
      divMap = 1'b0;
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
